eth_rx_fcs_check: RTL and testbench
===================================

ETH_RX_FCS_CHECK -- requirements
Module: eth_rx_fcs_check

Interface
REQ-001 SHALL have parameters: DATA_W, 8, byte width; CRC_W, 32, CRC width; CRC_POLY, 32'h04C11DB7, generator; CRC_INIT, 32'hFFFFFFFF, seed at frame start; CRC_RESIDUE, 32'hC704DD7B, good-frame register value after FCS; MIN_FRAME_BYTES, 64, runt threshold including FCS.
REQ-002 SHALL have ports: clk_i in 1 clock; rst_i in 1 reset; s_valid_i in 1 input byte valid; s_data_i in DATA_W byte (first-received bit in bit 0); s_sof_i in 1 first byte of frame; s_eof_i in 1 last byte of frame (FCS byte 4).
REQ-003 SHALL have ports: m_valid_o out 1; m_data_o out DATA_W; m_sof_o out 1; m_eof_o out 1; m_err_o out 1 (FCS or runt error, valid with m_eof_o).
REQ-004 SHALL have ports: stat_valid_o out 1 one-cycle frame-status pulse; stat_fcs_err_o out 1; stat_runt_o out 1; stat_abort_o out 1; stat_len_o out 16 payload bytes excluding FCS.
REQ-005 SHALL use one clock, clk_i; reset rst_i is asynchronous and active-high.
REQ-006 SHALL have no backpressure; input accepted every cycle s_valid_i=1.

Function
REQ-007 SHALL implement states IDLE and FRAME; IDLE->FRAME on s_valid_i&s_sof_i&!s_eof_i; FRAME->IDLE on accepted s_eof_i; s_sof_i&s_eof_i together = one-byte frame, stays IDLE.
REQ-008 SHALL ignore bytes in IDLE without s_sof_i; s_valid_i=0 cycles inside FRAME SHALL hold all state.
REQ-009 SHALL seed CRC with CRC_INIT on each s_sof_i byte and update it once per accepted byte, LSB of s_data_i first, non-reflected, no final XOR.
REQ-010 SHALL hold the last 4 accepted bytes in a 4-entry delay buffer; byte k (1-based) SHALL be emitted only when byte k+4 is accepted, so the 4 FCS bytes are never emitted.
REQ-011 SHALL register outputs: byte k+4 accepted in cycle t -> byte k on m_* in cycle t+1, m_valid_o=1 for exactly that cycle.
REQ-012 SHALL assert m_sof_o with byte 1 and m_eof_o with the byte emitted in the cycle after s_eof_i accepted.
REQ-013 SHALL set m_err_o = stat_fcs_err_o | stat_runt_o on the m_eof_o byte; 0 otherwise.
REQ-014 SHALL flag stat_fcs_err_o=1 when CRC after the eof byte != CRC_RESIDUE.
REQ-015 SHALL flag stat_runt_o=1 when total bytes including FCS < MIN_FRAME_BYTES.
REQ-016 SHALL, for frames of 4 bytes or fewer, emit no m_* bytes, stat_len_o=0, stat_runt_o=1.
REQ-017 SHALL pulse stat_valid_o in the cycle after eof acceptance, status fields valid in the same cycle, zero when stat_valid_o=0.
REQ-018 SHALL count payload in a 16-bit counter saturating at 16'hFFFF.
REQ-019 SHALL treat s_sof_i in FRAME as abort: stat_valid_o pulse next cycle with stat_abort_o=1, other flags 0, old buffer discarded, no m_eof_o for old frame; new frame starts with that byte.

Reset
REQ-020 SHALL on rst_i=1 drive all m_* and stat_* outputs to 0, state IDLE, buffer occupancy 0, length 0, CRC CRC_INIT.
REQ-021 SHALL drop a frame interrupted by reset silently; no eof or status emitted after release.

Structure
REQ-022 SHALL take CRC_POLY, CRC_INIT, CRC_RESIDUE and the state enum from the shared Ethernet package.
REQ-023 SHALL instantiate calculate_crc (DATA_W=8, CRC_W=32) as its only sub-module for the per-byte update.

Verification
REQ-024 "123456789" + 26 39 F4 CB, sof byte 1, eof byte 13 -> 9 bytes out 0x31..0x39, m_eof_o on 0x39, m_err_o=1, stat_fcs_err_o=0, stat_runt_o=1, stat_len_o=9.
REQ-025 64-byte frame, 60 payload + correct FCS, one idle gap mid-frame -> 60 bytes out, m_eof_o on byte 60, m_err_o=0, stat_len_o=60, all flags 0.
REQ-026 same frame, byte 10 XOR 0x01 -> stat_fcs_err_o=1, m_err_o=1, stat_len_o=60.
REQ-027 single byte with s_sof_i=s_eof_i=1 -> no m_valid_o, stat_valid_o=1, stat_runt_o=1, stat_len_o=0.
REQ-028 new s_sof_i at byte 20 of a frame -> stat_abort_o=1 next cycle, 15 bytes emitted for old frame, following 64-byte good frame checks clean.
REQ-029 rst_i pulse at byte 30 of a frame -> all outputs 0 within the reset, no stat_valid_o afterwards until next sof frame.

Source files
------------

// File: rtl/eth_rx_fcs_check_pkg.sv
// Shared Ethernet RX constants: CRC-32 generator, seed and good-frame residue,
// the frame-tracking state enum and a saturating counter helper.
package eth_rx_fcs_check_pkg;

    localparam logic [31:0] ETH_CRC_POLY    = 32'h04C11DB7;
    localparam logic [31:0] ETH_CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] ETH_CRC_RESIDUE = 32'hC704DD7B;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } eth_rx_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/eth_rx_fcs_check_if.sv
// Byte-stream bundle for the FCS checker: inbound bytes, outbound payload bytes
// and the per-frame status pulse. slave = checker side, master = source/sink side.
interface eth_rx_fcs_check_if #(parameter int DATA_W = 8) ();

    logic              s_valid_i;
    logic [DATA_W-1:0] s_data_i;
    logic              s_sof_i;
    logic              s_eof_i;

    logic              m_valid_o;
    logic [DATA_W-1:0] m_data_o;
    logic              m_sof_o;
    logic              m_eof_o;
    logic              m_err_o;

    logic              stat_valid_o;
    logic              stat_fcs_err_o;
    logic              stat_runt_o;
    logic              stat_abort_o;
    logic [15:0]       stat_len_o;

    modport master (
        output s_valid_i, s_data_i, s_sof_i, s_eof_i,
        input  m_valid_o, m_data_o, m_sof_o, m_eof_o, m_err_o,
        input  stat_valid_o, stat_fcs_err_o, stat_runt_o, stat_abort_o, stat_len_o
    );

    modport slave (
        input  s_valid_i, s_data_i, s_sof_i, s_eof_i,
        output m_valid_o, m_data_o, m_sof_o, m_eof_o, m_err_o,
        output stat_valid_o, stat_fcs_err_o, stat_runt_o, stat_abort_o, stat_len_o
    );

endinterface

// File: rtl/eth_rx_fcs_check_crc.sv
// Combinational CRC update for one data word, LSB of data_i shifted in first,
// MSB-first register, non-reflected, no final XOR.
module calculate_crc
    import eth_rx_fcs_check_pkg::*;
#(
    parameter int               DATA_W = 8,
    parameter int               CRC_W  = 32,
    parameter logic [CRC_W-1:0] POLY   = ETH_CRC_POLY
) (
    input  logic [CRC_W-1:0]  crc_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [CRC_W-1:0]  crc_o
);

    logic [CRC_W-1:0] c;
    logic             fb;

    always_comb begin
        c  = crc_i;
        fb = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            fb = c[CRC_W-1] ^ data_i[i];
            c  = {c[CRC_W-2:0], 1'b0};
            if (fb) begin
                c = c ^ POLY;
            end
        end
        crc_o = c;
    end

endmodule

// File: rtl/eth_rx_fcs_check.sv
// Strips and checks the Ethernet FCS; payload byte k leaves 1 cycle after byte k+4 arrives.
// No backpressure: every s_valid_i byte is consumed, status pulses 1 cycle after eof.
module eth_rx_fcs_check
    import eth_rx_fcs_check_pkg::*;
#(
    parameter int               DATA_W          = 8,
    parameter int               CRC_W           = 32,
    parameter logic [CRC_W-1:0] CRC_POLY        = ETH_CRC_POLY,
    parameter logic [CRC_W-1:0] CRC_INIT        = ETH_CRC_INIT,
    parameter logic [CRC_W-1:0] CRC_RESIDUE     = ETH_CRC_RESIDUE,
    parameter int               MIN_FRAME_BYTES = 64
) (
    input logic               clk_i,
    input logic               rst_i,
    eth_rx_fcs_check_if.slave bus
);

    localparam logic [15:0] MIN_PAYLOAD = 16'(MIN_FRAME_BYTES - 4);

    eth_rx_state_e     state_q, state_d;
    logic [CRC_W-1:0]  crc_q, crc_d, crc_seed, crc_new;
    logic [DATA_W-1:0] buf_q [4];
    logic [DATA_W-1:0] buf_d [4];
    logic [2:0]        occ_q, occ_d;
    logic [15:0]       pay_q, pay_d;
    logic              first_q, first_d;

    logic              m_valid_q, m_valid_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic              m_sof_q, m_sof_d;
    logic              m_eof_q, m_eof_d;
    logic              m_err_q, m_err_d;
    logic              st_valid_q, st_valid_d;
    logic              st_fcs_q, st_fcs_d;
    logic              st_runt_q, st_runt_d;
    logic              st_abort_q, st_abort_d;
    logic [15:0]       st_len_q, st_len_d;

    logic acc;
    logic emit;
    logic fcs_bad;
    logic runt;

    assign acc      = bus.s_valid_i;
    assign crc_seed = bus.s_sof_i ? CRC_INIT : crc_q;

    calculate_crc #(
        .DATA_W (DATA_W),
        .CRC_W  (CRC_W),
        .POLY   (CRC_POLY)
    ) u_crc (
        .crc_i  (crc_seed),
        .data_i (bus.s_data_i),
        .crc_o  (crc_new)
    );

    always_comb begin
        state_d    = state_q;
        crc_d      = crc_q;
        buf_d      = buf_q;
        occ_d      = occ_q;
        pay_d      = pay_q;
        first_d    = first_q;
        m_valid_d  = 1'b0;
        m_data_d   = '0;
        m_sof_d    = 1'b0;
        m_eof_d    = 1'b0;
        m_err_d    = 1'b0;
        st_valid_d = 1'b0;
        st_fcs_d   = 1'b0;
        st_runt_d  = 1'b0;
        st_abort_d = 1'b0;
        st_len_d   = '0;
        emit       = 1'b0;
        runt       = 1'b0;
        fcs_bad    = (crc_new != CRC_RESIDUE);

        if (acc && bus.s_sof_i) begin
            // A start byte always opens a fresh frame; an open one is reported as aborted.
            crc_d    = crc_new;
            buf_d[0] = bus.s_data_i;
            occ_d    = 3'd1;
            pay_d    = '0;
            first_d  = 1'b1;
            state_d  = ST_FRAME;
            if (state_q == ST_FRAME) begin
                st_valid_d = 1'b1;
                st_abort_d = 1'b1;
            end else if (bus.s_eof_i) begin
                st_valid_d = 1'b1;
                st_fcs_d   = fcs_bad;
                st_runt_d  = 1'b1;
            end
            if (bus.s_eof_i) begin
                state_d = ST_IDLE;
                occ_d   = '0;
            end
        end else if (acc && state_q == ST_FRAME) begin
            crc_d    = crc_new;
            buf_d[0] = bus.s_data_i;
            for (int i = 1; i < 4; i++) begin
                buf_d[i] = buf_q[i-1];
            end
            emit = (occ_q == 3'd4);
            if (emit) begin
                m_valid_d = 1'b1;
                m_data_d  = buf_q[3];
                m_sof_d   = first_q;
                first_d   = 1'b0;
                pay_d     = sat_inc16(pay_q);
            end else begin
                occ_d = occ_q + 3'd1;
            end
            if (bus.s_eof_i) begin
                runt       = (pay_d < MIN_PAYLOAD);
                state_d    = ST_IDLE;
                occ_d      = '0;
                st_valid_d = 1'b1;
                st_fcs_d   = fcs_bad;
                st_runt_d  = runt;
                st_len_d   = pay_d;
                m_eof_d    = emit;
                m_err_d    = emit & (fcs_bad | runt);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            crc_q      <= CRC_INIT;
            buf_q      <= '{default: '0};
            occ_q      <= '0;
            pay_q      <= '0;
            first_q    <= 1'b0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            m_sof_q    <= 1'b0;
            m_eof_q    <= 1'b0;
            m_err_q    <= 1'b0;
            st_valid_q <= 1'b0;
            st_fcs_q   <= 1'b0;
            st_runt_q  <= 1'b0;
            st_abort_q <= 1'b0;
            st_len_q   <= '0;
        end else begin
            state_q    <= state_d;
            crc_q      <= crc_d;
            buf_q      <= buf_d;
            occ_q      <= occ_d;
            pay_q      <= pay_d;
            first_q    <= first_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            m_sof_q    <= m_sof_d;
            m_eof_q    <= m_eof_d;
            m_err_q    <= m_err_d;
            st_valid_q <= st_valid_d;
            st_fcs_q   <= st_fcs_d;
            st_runt_q  <= st_runt_d;
            st_abort_q <= st_abort_d;
            st_len_q   <= st_len_d;
        end
    end

    assign bus.m_valid_o      = m_valid_q;
    assign bus.m_data_o       = m_data_q;
    assign bus.m_sof_o        = m_sof_q;
    assign bus.m_eof_o        = m_eof_q;
    assign bus.m_err_o        = m_err_q;
    assign bus.stat_valid_o   = st_valid_q;
    assign bus.stat_fcs_err_o = st_fcs_q;
    assign bus.stat_runt_o    = st_runt_q;
    assign bus.stat_abort_o   = st_abort_q;
    assign bus.stat_len_o     = st_len_q;

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// Bench for eth_rx_fcs_check: directed and random frames against a reflected CRC-32 frame model.
module tb_eth_rx_fcs_check;

    typedef logic [7:0] byte_t;

    typedef struct packed {
        logic [7:0]  d;
        logic        sof;
        logic        eof;
        logic        err;
        logic [31:0] cyc;
    } mrec_t;

    typedef struct packed {
        logic        fdc;
        logic        fcs;
        logic        runt;
        logic        abort;
        logic [15:0] len;
        logic [31:0] cyc;
    } srec_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    int    total = 0;
    int    bad = 0;
    int    n_neg = 0;
    byte_t frm[$];
    mrec_t exp_m[$];
    mrec_t act_m[$];
    srec_t exp_s[$];
    srec_t act_s[$];

    eth_rx_fcs_check_if #(.DATA_W(8)) bus ();

    eth_rx_fcs_check dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        n_neg++;
        if (bus.m_valid_o === 1'b1)
            act_m.push_back('{d: bus.m_data_o, sof: bus.m_sof_o, eof: bus.m_eof_o,
                              err: bus.m_err_o, cyc: 32'(n_neg)});
        if (bus.stat_valid_o === 1'b1)
            act_s.push_back('{fdc: 1'b0, fcs: bus.stat_fcs_err_o, runt: bus.stat_runt_o,
                              abort: bus.stat_abort_o, len: bus.stat_len_o, cyc: 32'(n_neg)});
        else
            chk("stat_zero_when_idle", 64'({bus.stat_fcs_err_o, bus.stat_runt_o,
                bus.stat_abort_o, bus.stat_len_o}), 64'd0);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Standard Ethernet CRC-32 (reflected) over the first n bytes of q.
    function automatic logic [31:0] crc32_ref(input byte_t q[$], input int n);
        logic [31:0] c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'd0, q[i]};
            for (int b = 0; b < 8; b++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic make_frame(input int npay);
        logic [31:0] c;
        frm.delete();
        for (int i = 0; i < npay; i++) frm.push_back(8'($urandom));
        c = crc32_ref(frm, npay);
        frm.push_back(c[7:0]);
        frm.push_back(c[15:8]);
        frm.push_back(c[23:16]);
        frm.push_back(c[31:24]);
    endtask

    task automatic drive_byte(input byte_t d, input logic sof, input logic eof, output int cyc);
        @(posedge clk);
        #1;
        bus.s_valid_i = 1'b1;
        bus.s_data_i  = d;
        bus.s_sof_i   = sof;
        bus.s_eof_i   = eof;
        cyc = n_neg + 2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            bus.s_valid_i = 1'b0;
            bus.s_data_i  = 8'($urandom);
            bus.s_sof_i   = 1'($urandom);
            bus.s_eof_i   = 1'($urandom);
        end
    endtask

    // Sends frm[0..n_send-1] and queues what the checker should produce for it.
    task automatic send_seq(input int n_send, input logic do_eof, input int gap_at,
                            input logic rgap, input logic abort_prev);
        int          cyc_of[$];
        int          c;
        logic        fcs;
        logic        runt;
        logic [31:0] got;
        fcs  = 1'b0;
        runt = (n_send < 64);
        if (do_eof && n_send >= 4) begin
            got = {frm[n_send-1], frm[n_send-2], frm[n_send-3], frm[n_send-4]};
            fcs = (crc32_ref(frm, n_send - 4) != got);
        end
        for (int i = 0; i < n_send; i++) begin
            if (i > 0 && (i == gap_at || (rgap && $urandom_range(0, 3) == 0))) idle(1);
            drive_byte(frm[i], i == 0, do_eof && (i == n_send - 1), c);
            cyc_of.push_back(c);
            if (i == 0 && abort_prev)
                exp_s.push_back('{fdc: 1'b0, fcs: 1'b0, runt: 1'b0, abort: 1'b1,
                                  len: 16'd0, cyc: 32'(c)});
        end
        for (int k = 0; k + 4 < n_send; k++)
            exp_m.push_back('{d: frm[k], sof: (k == 0), eof: do_eof && (k + 5 == n_send),
                              err: do_eof && (k + 5 == n_send) && (fcs || runt),
                              cyc: 32'(cyc_of[k+4])});
        if (do_eof)
            exp_s.push_back('{fdc: (n_send < 4), fcs: fcs, runt: runt, abort: 1'b0,
                              len: 16'((n_send > 4) ? n_send - 4 : 0),
                              cyc: 32'(cyc_of[n_send-1])});
    endtask

    task automatic compare_all(input string tag);
        srec_t a;
        srec_t e;
        chk({tag, "_mcount"}, 64'(act_m.size()), 64'(exp_m.size()));
        while (act_m.size() > 0 && exp_m.size() > 0)
            chk({tag, "_mbyte"}, 64'(act_m.pop_front()), 64'(exp_m.pop_front()));
        chk({tag, "_scount"}, 64'(act_s.size()), 64'(exp_s.size()));
        while (act_s.size() > 0 && exp_s.size() > 0) begin
            a = act_s.pop_front();
            e = exp_s.pop_front();
            if (e.fdc) begin
                a.fdc = 1'b1;
                a.fcs = e.fcs;
            end
            chk({tag, "_stat"}, 64'(a), 64'(e));
        end
        act_m.delete();
        exp_m.delete();
        act_s.delete();
        exp_s.delete();
    endtask

    initial begin
        int c;
        int idx;
        bus.s_valid_i = 1'b0;
        bus.s_data_i  = 8'd0;
        bus.s_sof_i   = 1'b0;
        bus.s_eof_i   = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs", 64'({bus.m_valid_o, bus.m_data_o, bus.m_sof_o, bus.m_eof_o,
            bus.m_err_o, bus.stat_valid_o, bus.stat_fcs_err_o, bus.stat_runt_o,
            bus.stat_abort_o, bus.stat_len_o}), 64'd0);
        rst = 1'b0;
        idle(2);

        // "123456789" with its known good FCS: short frame, so runt but FCS clean.
        frm.delete();
        for (int i = 0; i < 9; i++) frm.push_back(8'h31 + 8'(i));
        frm.push_back(8'h26);
        frm.push_back(8'h39);
        frm.push_back(8'hF4);
        frm.push_back(8'hCB);
        send_seq(13, 1'b1, -1, 1'b0, 1'b0);
        idle(5);
        compare_all("check_string");

        make_frame(60);
        send_seq(64, 1'b1, 30, 1'b0, 1'b0);
        idle(5);
        compare_all("good64");

        frm[9] = frm[9] ^ 8'h01;
        send_seq(64, 1'b1, 30, 1'b0, 1'b0);
        idle(5);
        compare_all("fcs_err64");

        frm.delete();
        frm.push_back(8'hA5);
        send_seq(1, 1'b1, -1, 1'b0, 1'b0);
        idle(5);
        compare_all("one_byte");

        make_frame(60);
        send_seq(19, 1'b0, -1, 1'b0, 1'b0);
        make_frame(60);
        send_seq(64, 1'b1, -1, 1'b0, 1'b1);
        idle(5);
        compare_all("abort");

        // Reset lands on byte 30; the rest of that frame then arrives without a sof.
        make_frame(60);
        send_seq(29, 1'b0, -1, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b1;
        bus.s_valid_i = 1'b1;
        bus.s_data_i  = frm[29];
        bus.s_sof_i   = 1'b0;
        bus.s_eof_i   = 1'b0;
        @(negedge clk);
        #1;
        chk("reset_mid_frame", 64'({bus.m_valid_o, bus.m_data_o, bus.m_sof_o, bus.m_eof_o,
            bus.m_err_o, bus.stat_valid_o, bus.stat_fcs_err_o, bus.stat_runt_o,
            bus.stat_abort_o, bus.stat_len_o}), 64'd0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        for (int i = 30; i < 64; i++) drive_byte(frm[i], 1'b0, i == 63, c);
        idle(5);
        compare_all("reset_drop");

        make_frame(60);
        send_seq(64, 1'b1, -1, 1'b1, 1'b0);
        idle(5);
        compare_all("post_reset");

        for (int it = 0; it < 16; it++) begin
            case (it % 8)
                0:       make_frame(0);
                1:       make_frame(59);
                2:       make_frame(60);
                3:       make_frame(61);
                4:       make_frame(1);
                default: make_frame(int'($urandom_range(2, 90)));
            endcase
            if ($urandom_range(0, 2) == 0) begin
                idx = int'($urandom_range(0, frm.size() - 1));
                frm[idx] = frm[idx] ^ 8'(1 << $urandom_range(0, 7));
            end
            send_seq(frm.size(), 1'b1, -1, 1'b1, 1'b0);
            idle(int'($urandom_range(1, 4)));
        end
        idle(5);
        compare_all("random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
